// File: rtl/fpu_bus_if.sv
// FPU-side responder on the 8-bit host register bus: operand/opcode capture,
// start/done handshake with the arithmetic core, result readback and watchdog.
module fpu_bus_if #(
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter logic [31:0] NAN_VALUE      = 32'h7FC00000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  databus_in,
    output logic [7:0]  databus_out,
    input  logic [3:0]  addr,
    input  logic        cs,
    input  logic        rd,
    input  logic        wr,
    input  logic        end_ack,
    output logic        cmd_end,
    output logic        busy,
    output logic        core_start,
    output logic [7:0]  core_op,
    output logic [31:0] core_a,
    output logic [31:0] core_b,
    input  logic        core_done,
    input  logic [31:0] core_result
);

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_END} state_t;

    state_t      state;
    state_t      state_next;
    logic        wr_q;
    logic [31:0] a_reg;
    logic [31:0] b_reg;
    logic [7:0]  op_reg;
    logic [31:0] result;
    logic        err;
    logic        tmo;
    logic [31:0] wdog;
    logic        commit;
    logic        reg_write;
    logic        start_cmd;
    logic        timed_out;
    logic [7:0]  rdata;

    // A commit happens only on the falling edge of wr, so a long strobe writes once.
    assign commit    = !cs && wr_q && !wr;
    assign reg_write = commit && (addr <= 4'd9);
    assign start_cmd = commit && (addr == 4'd9) && (state == S_IDLE);
    assign timed_out = (TIMEOUT_CYCLES != 0) && (wdog == 32'd1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:   if (start_cmd) state_next = S_LAUNCH;
            S_LAUNCH: state_next = S_WAIT;
            S_WAIT:   if (core_done || timed_out) state_next = S_END;
            S_END:    if (end_ack) state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q   <= 1'b1;
            a_reg  <= '0;
            b_reg  <= '0;
            op_reg <= '0;
            result <= '0;
            err    <= 1'b0;
            tmo    <= 1'b0;
            wdog   <= '0;
        end else begin
            wr_q <= wr;
            if (reg_write) begin
                if (state == S_IDLE) begin
                    case (addr)
                        4'd0, 4'd1, 4'd2, 4'd3: a_reg[{addr[1:0], 3'b000} +: 8] <= databus_in;
                        4'd4, 4'd5, 4'd6, 4'd7: b_reg[{addr[1:0], 3'b000} +: 8] <= databus_in;
                        4'd8:                   op_reg <= databus_in;
                        default: ;
                    endcase
                end else begin
                    err <= 1'b1;
                end
            end
            if (start_cmd) begin
                wdog <= 32'(TIMEOUT_CYCLES);
            end
            if (commit && (addr == 4'hD)) begin
                err <= 1'b0;
                tmo <= 1'b0;
            end
            // core_done takes precedence over a simultaneous watchdog expiry.
            if (state == S_WAIT) begin
                if (core_done) begin
                    result <= core_result;
                end else if (timed_out) begin
                    result <= NAN_VALUE;
                    tmo    <= 1'b1;
                end else begin
                    wdog <= wdog - 32'd1;
                end
            end
        end
    end

    assign busy       = (state == S_LAUNCH) || (state == S_WAIT);
    assign cmd_end    = (state == S_END);
    assign core_start = (state == S_LAUNCH);
    assign core_op    = op_reg;
    assign core_a     = a_reg;
    assign core_b     = b_reg;

    always_comb begin
        rdata = '0;
        case (addr)
            4'h0: rdata = a_reg[7:0];
            4'h1: rdata = a_reg[15:8];
            4'h2: rdata = a_reg[23:16];
            4'h3: rdata = a_reg[31:24];
            4'h4: rdata = b_reg[7:0];
            4'h5: rdata = b_reg[15:8];
            4'h6: rdata = b_reg[23:16];
            4'h7: rdata = b_reg[31:24];
            4'h8: rdata = op_reg;
            4'h9: rdata = result[7:0];
            4'hA: rdata = result[15:8];
            4'hB: rdata = result[23:16];
            4'hC: rdata = result[31:24];
            4'hD: rdata = {busy, cmd_end, err, tmo, 4'b0000};
            default: rdata = '0;
        endcase
    end

    assign databus_out = (!cs && !rd) ? rdata : '0;

endmodule

// File: tb/tb_fpu_bus_if.sv
// Bench for fpu_bus_if: directed scenarios plus random host traffic, checked
// every cycle against a transaction-level model of the register block.
module tb_fpu_bus_if;

    localparam int unsigned TMO = 16;
    localparam logic [31:0] NAN = 32'h7FC00000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  databus_in = '0;
    logic [7:0]  databus_out;
    logic [3:0]  addr = '0;
    logic        cs = 1'b1;
    logic        rd = 1'b1;
    logic        wr = 1'b1;
    logic        end_ack = 1'b0;
    logic        cmd_end;
    logic        busy;
    logic        core_start;
    logic [7:0]  core_op;
    logic [31:0] core_a;
    logic [31:0] core_b;
    logic        core_done = 1'b0;
    logic [31:0] core_result = '0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fpu_bus_if #(.TIMEOUT_CYCLES(TMO), .NAN_VALUE(NAN)) dut (
        .clk(clk), .rst_n(rst_n), .databus_in(databus_in), .databus_out(databus_out),
        .addr(addr), .cs(cs), .rd(rd), .wr(wr), .end_ack(end_ack), .cmd_end(cmd_end),
        .busy(busy), .core_start(core_start), .core_op(core_op), .core_a(core_a),
        .core_b(core_b), .core_done(core_done), .core_result(core_result)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Core emulator: -1 random latency, 0 never answers, n answers n negedges after launch.
    int          core_lat = -1;
    bit          res_forced = 1'b0;
    logic [31:0] res_value = '0;
    int          core_cnt = 0;

    always @(negedge clk) begin
        core_done = 1'b0;
        if (core_cnt > 0) begin
            core_cnt--;
            if (core_cnt == 0) begin
                core_done = 1'b1;
                core_result = res_forced ? res_value : $urandom;
            end
        end
        if (core_start) core_cnt = (core_lat < 0) ? int'($urandom_range(1, 20)) : core_lat;
    end

    // Transaction-level model: flags for "launch pending", "core running", "finished".
    bit          m_launch, m_run, m_fin, m_err, m_tmo;
    bit          o_launch, o_run, o_fin, m_commit;
    int          m_left;
    logic [31:0] m_a, m_b, m_res;
    logic [7:0]  m_op;
    logic        m_wr_prev = 1'b1;

    function automatic logic [7:0] m_read(input logic [3:0] a);
        if (a <= 3)       return 8'(m_a >> (8 * a));
        else if (a <= 7)  return 8'(m_b >> (8 * (a - 4)));
        else if (a == 8)  return m_op;
        else if (a <= 12) return 8'(m_res >> (8 * (a - 9)));
        else if (a == 13) return {m_launch | m_run, m_fin, m_err, m_tmo, 4'b0000};
        else              return 8'h00;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_launch = 0; m_run = 0; m_fin = 0; m_err = 0; m_tmo = 0; m_left = 0;
            m_a = '0; m_b = '0; m_res = '0; m_op = '0;
        end else begin
            o_launch = m_launch; o_run = m_run; o_fin = m_fin;
            m_commit = !cs && m_wr_prev && !wr;
            if (m_commit && addr <= 9) begin
                if (!(o_launch || o_run || o_fin)) begin
                    if (addr <= 3)      m_a[8 * addr +: 8] = databus_in;
                    else if (addr <= 7) m_b[8 * (addr - 4) +: 8] = databus_in;
                    else if (addr == 8) m_op = databus_in;
                    else begin m_launch = 1; m_left = TMO; end
                end else begin
                    m_err = 1;
                end
            end
            if (m_commit && addr == 13) begin m_err = 0; m_tmo = 0; end
            if (o_launch) begin m_launch = 0; m_run = 1; end
            if (o_run) begin
                if (core_done) begin
                    m_res = core_result; m_run = 0; m_fin = 1;
                end else if (TMO != 0) begin
                    m_left--;
                    if (m_left == 0) begin m_res = NAN; m_tmo = 1; m_run = 0; m_fin = 1; end
                end
            end
            if (o_fin && end_ack) m_fin = 0;
        end
        m_wr_prev = rst_n ? wr : 1'b1;
        #1;
        chk("busy", busy, m_launch | m_run);
        chk("cmd_end", cmd_end, m_fin);
        chk("core_start", core_start, m_launch);
        chk("core_a", core_a, m_a);
        chk("core_b", core_b, m_b);
        chk("core_op", core_op, m_op);
        chk("databus_out", databus_out, (!cs && !rd) ? m_read(addr) : 8'h00);
    end

    task automatic wr_byte(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk); cs = 0; wr = 0; addr = a; databus_in = d;
        @(negedge clk); wr = 1; cs = 1;
    endtask

    task automatic wr_rd_byte(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk); cs = 0; wr = 0; rd = 0; addr = a; databus_in = d;
        @(negedge clk); wr = 1; rd = 1; cs = 1;
    endtask

    task automatic rd_chk(input string name, input logic [3:0] a, input logic [7:0] exp);
        @(negedge clk); cs = 0; rd = 0; addr = a;
        #1 chk(name, databus_out, exp);
        @(negedge clk); rd = 1; cs = 1;
    endtask

    task automatic wr_word(input logic [3:0] base, input logic [31:0] w);
        for (int i = 0; i < 4; i++) wr_byte(base + 4'(i), w[8 * i +: 8]);
    endtask

    task automatic wait_end(input string name, output int n);
        n = 0;
        while (!cmd_end && n < 100) begin @(negedge clk); n++; end
        chk(name, cmd_end, 1);
    endtask

    task automatic ack();
        @(negedge clk); end_ack = 1;
        @(negedge clk); end_ack = 0;
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        rst_n = 1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_cmd_end", cmd_end, 0);
        chk("rst_core_a", core_a, 0);

        // Byte order
        wr_word(0, 32'h4cbebc20);
        chk("byte_order_core_a", core_a, 32'h4cbebc20);
        rd_chk("rd_a0", 0, 8'h20); rd_chk("rd_a1", 1, 8'hbc);
        rd_chk("rd_a2", 2, 8'hbe); rd_chk("rd_a3", 3, 8'h4c);

        // Reference operation 1.0 + 1.1
        wr_word(0, 32'h3f800000);
        wr_word(4, 32'h3f8ccccd);
        wr_byte(8, 8'h02);
        core_lat = 5; res_forced = 1; res_value = 32'h40066666;
        wr_byte(9, 8'h00);
        wait_end("ref_end", n);
        rd_chk("ref_r0", 9, 8'h66); rd_chk("ref_r1", 10, 8'h66);
        rd_chk("ref_r2", 11, 8'h06); rd_chk("ref_r3", 12, 8'h40);
        rd_chk("ref_status", 13, 8'h40);
        ack();
        #1 chk("ref_ack_cmd_end", cmd_end, 0);
        chk("ref_core_b", core_b, 32'h3f8ccccd);

        // Busy protection and watchdog result
        core_lat = 0;
        wr_byte(9, 8'h00);
        wr_byte(0, 8'hFF);
        rd_chk("prot_status", 13, 8'hA0);
        chk("prot_core_a", core_a, 32'h3f800000);
        wr_byte(13, 8'h00);
        rd_chk("prot_clear", 13, 8'h80);
        wait_end("tmo_end", n);
        rd_chk("nan_r0", 9, 8'h00); rd_chk("nan_r1", 10, 8'h00);
        rd_chk("nan_r2", 11, 8'hc0); rd_chk("nan_r3", 12, 8'h7f);
        rd_chk("tmo_status", 13, 8'h50);
        ack();
        wr_byte(13, 8'h00);

        // Watchdog latency: START commit edge + 1 launch + 16 wait cycles
        wr_byte(9, 8'h00);
        wait_end("tmo2_end", n);
        chk("tmo_latency", n, 17);
        ack();
        wr_byte(13, 8'h00);

        // core_done coincides with watchdog expiry
        core_lat = 16; res_value = 32'h12345678;
        wr_byte(9, 8'h00);
        wait_end("tie_end", n);
        chk("tie_latency", n, 17);
        rd_chk("tie_status", 13, 8'h40);
        rd_chk("tie_r0", 9, 8'h78);
        ack();

        // Reset in the middle of WAIT
        core_lat = 10;
        wr_byte(9, 8'h00);
        repeat (3) @(negedge clk);
        rst_n = 0;
        @(negedge clk); rst_n = 1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_cmd_end", cmd_end, 0);
        chk("midrst_core_a", core_a, 0);
        chk("midrst_core_op", core_op, 0);
        repeat (15) @(negedge clk);
        chk("midrst_late_done", cmd_end, 0);

        // Long wr strobe gives a single commit
        core_lat = 3;
        wr_byte(0, 8'h5A);
        @(negedge clk); cs = 0; wr = 0; addr = 9;
        repeat (3) @(negedge clk);
        wr = 1; cs = 1;
        wait_end("strobe_end", n);
        rd_chk("strobe_status", 13, 8'h40);
        ack();
        @(negedge clk); cs = 1; rd = 0; addr = 0;
        #1 chk("cs_high_read", databus_out, 8'h00);
        @(negedge clk); cs = 0;
        #1 chk("cs_low_read", databus_out, 8'h5A);
        @(negedge clk); cs = 1; rd = 1;

        // Random traffic
        core_lat = -1; res_forced = 0;
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: wr_byte(4'($urandom), 8'($urandom));
                3:       wr_byte(9, 8'($urandom));
                4: begin
                    @(negedge clk); cs = 0; rd = 0; addr = 4'($urandom);
                    @(negedge clk); rd = 1; cs = 1;
                end
                5: ack();
                6: repeat ($urandom_range(1, 8)) @(negedge clk);
                7: wr_rd_byte(4'($urandom), 8'($urandom));
                8: wr_byte(13, 8'h00);
                default: begin
                    if ($urandom_range(0, 19) == 0) begin
                        @(negedge clk); rst_n = 0;
                        @(negedge clk); rst_n = 1;
                    end else begin
                        @(negedge clk);
                    end
                end
            endcase
        end
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        failures++;
        $display("FAIL global_timeout actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
